// File: rtl/fetch_sequencer.sv
// Run-control and fetch-address sequencer feeding instr_ROM: starts on req, applies
// absolute/relative branches, holds on stall, halts at HALT_ADDR and keeps saturating counters.
module fetch_sequencer #(
  parameter int D         = 10,
  parameter int HALT_ADDR = 128,
  parameter int CYC_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             absjump_en,
  input  logic [D-1:0]     target,
  input  logic             reljump_en,
  input  logic [7:0]       rel_offset,
  input  logic             stall,
  output logic [D-1:0]     prog_ctr,
  output logic             fetch_valid,
  output logic             done,
  output logic [CYC_W-1:0] cycle_count,
  output logic [CYC_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [D-1:0] HALT_PC = D'(HALT_ADDR);

  state_t           state_r, state_nxt_s;
  logic [D-1:0]     pc_nxt_s, branch_pc_s;
  logic             fv_nxt_s, done_nxt_s;
  logic [CYC_W-1:0] cyc_nxt_s, ins_nxt_s;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    logic [CYC_W-1:0] r;
    if (v == {CYC_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CYC_W'(1);
    end
    return r;
  endfunction

  // Address of the next instruction; absolute branch wins over relative.
  always_comb begin
    branch_pc_s = prog_ctr + D'(1);
    if (absjump_en) begin
      branch_pc_s = target;
    end else if (reljump_en) begin
      branch_pc_s = prog_ctr + D'($signed(rel_offset));
    end else begin
      branch_pc_s = prog_ctr + D'(1);
    end
  end

  // Next-state and next-output logic for the run-control FSM.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = prog_ctr;
    fv_nxt_s    = fetch_valid;
    done_nxt_s  = done;
    cyc_nxt_s   = cycle_count;
    ins_nxt_s   = instr_count;
    case (state_r)
      IDLE, DONE: begin
        if (req) begin
          state_nxt_s = RUN;
          pc_nxt_s    = '0;
          fv_nxt_s    = 1'b1;
          done_nxt_s  = 1'b0;
          cyc_nxt_s   = '0;
          ins_nxt_s   = '0;
        end else begin
          pc_nxt_s   = (state_r == DONE) ? HALT_PC : '0;
          fv_nxt_s   = 1'b0;
          done_nxt_s = (state_r == DONE);
        end
      end
      RUN: begin
        cyc_nxt_s = sat_inc(cycle_count);
        if (stall) begin
          state_nxt_s = HOLD;
          fv_nxt_s    = 1'b0;
        end else begin
          ins_nxt_s = sat_inc(instr_count);
          if (branch_pc_s == HALT_PC) begin
            state_nxt_s = DONE;
            pc_nxt_s    = HALT_PC;
            fv_nxt_s    = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            pc_nxt_s = branch_pc_s;
            fv_nxt_s = 1'b1;
          end
        end
      end
      HOLD: begin
        // The held instruction is re-presented once the stall lifts.
        cyc_nxt_s = sat_inc(cycle_count);
        if (!stall) begin
          state_nxt_s = RUN;
          fv_nxt_s    = 1'b1;
        end else begin
          fv_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        pc_nxt_s    = '0;
        fv_nxt_s    = 1'b0;
        done_nxt_s  = 1'b0;
        cyc_nxt_s   = '0;
        ins_nxt_s   = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      prog_ctr    <= '0;
      fetch_valid <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state_r     <= state_nxt_s;
      prog_ctr    <= pc_nxt_s;
      fetch_valid <= fv_nxt_s;
      done        <= done_nxt_s;
      cycle_count <= cyc_nxt_s;
      instr_count <= ins_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural model; a CYC_W=4 copy checks saturation.
module tb_fetch_sequencer;
  localparam int D    = 10;
  localparam int HALT = 128;
  localparam int PCM  = 1 << D;

  logic         clk = 1'b0;
  logic         reset, req, absjump_en, reljump_en, stall;
  logic [D-1:0] target;
  logic [7:0]   rel_offset;
  logic [D-1:0] pc_a, pc_b;
  logic         fv_a, fv_b, done_a, done_b;
  logic [15:0]  cyc_a, ins_a;
  logic [3:0]   cyc_b, ins_b;

  always #5 clk = ~clk;

  fetch_sequencer #(.D(D), .HALT_ADDR(HALT), .CYC_W(16)) dut_a (
    .clk(clk), .reset(reset), .req(req), .absjump_en(absjump_en), .target(target),
    .reljump_en(reljump_en), .rel_offset(rel_offset), .stall(stall),
    .prog_ctr(pc_a), .fetch_valid(fv_a), .done(done_a),
    .cycle_count(cyc_a), .instr_count(ins_a));

  fetch_sequencer #(.D(D), .HALT_ADDR(HALT), .CYC_W(4)) dut_b (
    .clk(clk), .reset(reset), .req(req), .absjump_en(absjump_en), .target(target),
    .reljump_en(reljump_en), .rel_offset(rel_offset), .stall(stall),
    .prog_ctr(pc_b), .fetch_valid(fv_b), .done(done_b),
    .cycle_count(cyc_b), .instr_count(ins_b));

  int total = 0;
  int bad   = 0;

  // Behavioural model: running/holding flags plus plain integer PC and counts.
  bit m_run, m_hold, m_done;
  int m_pc, m_cyc, m_ins;

  typedef struct {
    bit req; bit abs; int tgt; bit rel; logic [7:0] off; bit stl;
    int exp_pc; bit exp_fv; bit exp_done;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_hold = 0; m_done = 0; m_pc = 0; m_cyc = 0; m_ins = 0;
  endtask

  task automatic model_step();
    int npc;
    if (!m_run) begin
      if (req) begin
        m_run = 1; m_hold = 0; m_done = 0; m_pc = 0; m_cyc = 0; m_ins = 0;
      end
    end else if (m_hold) begin
      m_cyc++;
      if (!stall) m_hold = 0;
    end else begin
      m_cyc++;
      if (stall) begin
        m_hold = 1;
      end else begin
        m_ins++;
        if (absjump_en) npc = int'(target);
        else if (reljump_en) npc = m_pc + int'($signed(rel_offset));
        else npc = m_pc + 1;
        npc = ((npc % PCM) + PCM) % PCM;
        if (npc == HALT) begin
          m_run = 0; m_done = 1; m_pc = HALT;
        end else begin
          m_pc = npc;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " pc"}, pc_a, m_pc);
    chk({tag, " fetch_valid"}, fv_a, (m_run && !m_hold) ? 1 : 0);
    chk({tag, " done"}, done_a, m_done);
    chk({tag, " cycle_count"}, cyc_a, sat(m_cyc, 65535));
    chk({tag, " instr_count"}, ins_a, sat(m_ins, 65535));
    chk({tag, " pc_w4"}, pc_b, m_pc);
    chk({tag, " cycle_count_w4"}, cyc_b, sat(m_cyc, 15));
    chk({tag, " instr_count_w4"}, ins_b, sat(m_ins, 15));
  endtask

  task automatic drive(input bit r, input bit a, input int t, input bit rl, input logic [7:0] o, input bit s);
    req = r; absjump_en = a; target = D'(t); reljump_en = rl; rel_offset = o; stall = s;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  function automatic vec_t mk(input bit r, input bit a, input int t, input bit rl, input logic [7:0] o,
                              input bit s, input int epc, input bit efv, input bit ed);
    vec_t v;
    v.req = r; v.abs = a; v.tgt = t; v.rel = rl; v.off = o; v.stl = s;
    v.exp_pc = epc; v.exp_fv = efv; v.exp_done = ed;
    return v;
  endfunction

  initial begin
    int c0, i0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 0);
    model_reset();
    #12;
    chk("reset pc", pc_a, 0);
    chk("reset fetch_valid", fv_a, 0);
    chk("reset done", done_a, 0);
    chk("reset cycle_count", cyc_a, 0);
    chk("reset instr_count", ins_a, 0);
    reset = 1'b0;

    // Straight-line run from 0 to the halt address.
    step("idle");
    drive(1, 0, 0, 0, 8'h00, 0);
    step("start");
    drive(0, 0, 0, 0, 8'h00, 0);
    for (int k = 0; k < 128; k++) step("linear");
    chk("linear end pc", pc_a, 128);
    chk("linear end done", done_a, 1);
    chk("linear end fetch_valid", fv_a, 0);
    chk("linear end instr_count", ins_a, 128);
    chk("linear end cycle_count", cyc_a, 128);

    // Directed vectors, starting from DONE.
    vecs.push_back(mk(1, 0, 0,   0, 8'h00, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 0,   0, 8'h00, 0, 1,    1, 0));
    vecs.push_back(mk(0, 0, 0,   0, 8'h00, 0, 2,    1, 0));
    vecs.push_back(mk(0, 0, 0,   0, 8'h00, 0, 3,    1, 0));
    vecs.push_back(mk(0, 0, 0,   1, 8'hFC, 0, 1023, 1, 0));
    vecs.push_back(mk(0, 0, 0,   0, 8'h00, 0, 0,    1, 0));
    vecs.push_back(mk(0, 1, 5,   0, 8'h00, 0, 5,    1, 0));
    vecs.push_back(mk(0, 1, 40,  1, 8'h10, 0, 40,   1, 0));
    vecs.push_back(mk(0, 0, 0,   0, 8'h00, 1, 40,   0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 8'h00, 0, 40,   1, 0));
    vecs.push_back(mk(0, 0, 0,   1, 8'h58, 0, 128,  0, 1));
    vecs.push_back(mk(0, 1, 7,   1, 8'h05, 1, 128,  0, 1));
    vecs.push_back(mk(1, 0, 0,   0, 8'h00, 0, 0,    1, 0));
    vecs.push_back(mk(1, 0, 0,   0, 8'h00, 0, 1,    1, 0));
    vecs.push_back(mk(0, 1, 127, 0, 8'h00, 0, 127,  1, 0));
    vecs.push_back(mk(0, 0, 0,   1, 8'h02, 0, 129,  1, 0));
    vecs.push_back(mk(0, 0, 0,   0, 8'h00, 0, 130,  1, 0));
    vecs.push_back(mk(0, 0, 0,   1, 8'h80, 0, 2,    1, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].abs, vecs[i].tgt, vecs[i].rel, vecs[i].off, vecs[i].stl);
      step("vec");
      chk($sformatf("vec%0d pc", i), pc_a, vecs[i].exp_pc);
      chk($sformatf("vec%0d fetch_valid", i), fv_a, vecs[i].exp_fv);
      chk($sformatf("vec%0d done", i), done_a, vecs[i].exp_done);
    end

    // Three stall cycles at pc 10.
    drive(0, 1, 10, 0, 8'h00, 0);
    step("to10");
    c0 = m_cyc; i0 = m_ins;
    drive(0, 1, 77, 1, 8'h11, 1);
    for (int k = 0; k < 3; k++) begin
      step("stall");
      chk("stall pc", pc_a, 10);
      chk("stall fetch_valid", fv_a, 0);
    end
    chk("stall cycle_count", cyc_a, c0 + 3);
    chk("stall instr_count", ins_a, i0);
    drive(0, 0, 0, 0, 8'h00, 0);
    step("resume");
    chk("resume pc", pc_a, 10);
    chk("resume fetch_valid", fv_a, 1);
    chk("resume instr_count", ins_a, i0);
    step("after resume");
    chk("after resume pc", pc_a, 11);

    // Asynchronous reset in the middle of a run.
    drive(0, 1, 50, 0, 8'h00, 0);
    step("to50");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async reset pc", pc_a, 0);
    chk("async reset done", done_a, 0);
    chk("async reset fetch_valid", fv_a, 0);
    chk("async reset cycle_count", cyc_a, 0);
    chk("async reset instr_count", ins_a, 0);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 8'h00, 0);
    step("post reset idle");
    step("post reset idle");
    drive(1, 0, 0, 0, 8'h00, 0);
    step("restart");

    // Twenty instructions: the 4-bit counters must pin at 15.
    drive(0, 1, 109, 0, 8'h00, 0);
    step("sat jump");
    drive(0, 0, 0, 0, 8'h00, 0);
    for (int k = 0; k < 19; k++) step("sat run");
    chk("sat done", done_b, 1);
    chk("sat pc", pc_b, 128);
    chk("sat instr_count w16", ins_a, 20);
    chk("sat instr_count w4", ins_b, 15);
    drive(1, 0, 0, 0, 8'h00, 0);
    step("done restart");
    chk("done restart pc", pc_a, 0);
    chk("done restart done", done_a, 0);
    chk("done restart fetch_valid", fv_a, 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      int t;
      t = ($urandom_range(0, 3) == 0) ? HALT : int'($urandom_range(0, PCM - 1));
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0), t,
            ($urandom_range(0, 6) == 0), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0));
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
